// File: rtl/fetch_stall_ctrl_if.sv
// Fetch-side hazard bus: stall/flush requests and imem data in, pipeline state and counters out.
interface fetch_stall_ctrl_if #(
  parameter int unsigned N     = 64,
  parameter int unsigned CNT_W = 32
);
  logic             stall;
  logic             flush;
  logic [N-1:0]     branch_target;
  logic [31:0]      imem_instr;
  logic [N-1:0]     IF_pc;
  logic [N-1:0]     ID_pc;
  logic [31:0]      ID_instr;
  logic             ID_valid;
  logic             EX_bubble;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  logic             stall_err;

  // Environment side: hazard unit, branch resolver and instruction memory.
  modport master (
    output stall, flush, branch_target, imem_instr,
    input  IF_pc, ID_pc, ID_instr, ID_valid, EX_bubble, stall_count, flush_count, stall_err
  );

  // Controller side.
  modport slave (
    input  stall, flush, branch_target, imem_instr,
    output IF_pc, ID_pc, ID_instr, ID_valid, EX_bubble, stall_count, flush_count, stall_err
  );
endinterface

// File: rtl/fetch_stall_ctrl.sv
// PC and IF/ID register owner: sequences flush > stall > run, keeps saturating
// perf counters and a sticky watchdog for runaway stalls.
module fetch_stall_ctrl #(
  parameter int unsigned N         = 64,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned MAX_STALL = 2
) (
  input logic              clk,
  input logic              reset,
  fetch_stall_ctrl_if.slave bus
);

  // Consecutive-stall counter only needs to reach MAX_STALL+1, where it saturates.
  localparam int unsigned SW = $clog2(MAX_STALL + 2);
  localparam logic [SW-1:0] ConsecSat   = SW'(MAX_STALL + 1);
  localparam logic [SW-1:0] ConsecLimit = SW'(MAX_STALL);

  logic [N-1:0]     r_if_pc;
  logic [N-1:0]     r_id_pc;
  logic [31:0]      r_id_instr;
  logic             r_id_valid;
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;
  logic             r_stall_err;
  logic [SW-1:0]    r_consec;

  logic w_flush;
  logic w_stall_eff;

  assign w_flush     = bus.flush;
  assign w_stall_eff = bus.stall & ~bus.flush;

  // Pipeline registers, counters and watchdog; flush has priority over stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_if_pc       <= RESET_PC;
      r_id_pc       <= '0;
      r_id_instr    <= '0;
      r_id_valid    <= 1'b0;
      r_stall_count <= '0;
      r_flush_count <= '0;
      r_stall_err   <= 1'b0;
      r_consec      <= '0;
    end else if (w_flush) begin
      r_if_pc    <= bus.branch_target;
      r_id_pc    <= '0;
      r_id_instr <= '0;
      r_id_valid <= 1'b0;
      r_consec   <= '0;
      if (r_flush_count != {CNT_W{1'b1}}) r_flush_count <= r_flush_count + 1'b1;
    end else if (w_stall_eff) begin
      if (r_stall_count != {CNT_W{1'b1}}) r_stall_count <= r_stall_count + 1'b1;
      if (r_consec != ConsecSat) r_consec <= r_consec + 1'b1;
      // This stall pushes the run length past the limit.
      if (r_consec >= ConsecLimit) r_stall_err <= 1'b1;
    end else begin
      r_if_pc    <= r_if_pc + N'(4);
      r_id_pc    <= r_if_pc;
      r_id_instr <= bus.imem_instr;
      r_id_valid <= 1'b1;
      r_consec   <= '0;
    end
  end

  // Bubble must reach ID/EX in the same cycle as the request.
  always_comb begin
    bus.EX_bubble = bus.flush | bus.stall;
  end

  assign bus.IF_pc       = r_if_pc;
  assign bus.ID_pc       = r_id_pc;
  assign bus.ID_instr    = r_id_instr;
  assign bus.ID_valid    = r_id_valid;
  assign bus.stall_count = r_stall_count;
  assign bus.flush_count = r_flush_count;
  assign bus.stall_err   = r_stall_err;

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Directed plus randomized bench for fetch_stall_ctrl against a cycle-level reference model.
module tb_fetch_stall_ctrl;
  localparam int unsigned N         = 64;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned MAX_STALL = 2;
  localparam int unsigned CNT_MAX   = (1 << CNT_W) - 1;

  logic clk;
  logic reset;

  fetch_stall_ctrl_if #(.N(N), .CNT_W(CNT_W)) bus ();

  fetch_stall_ctrl #(
    .N        (N),
    .RESET_PC ('0),
    .CNT_W    (CNT_W),
    .MAX_STALL(MAX_STALL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: data is a simple function of the address.
  assign bus.imem_instr = 32'hA000_0000 + bus.IF_pc[31:0];

  int n_cmp = 0;
  int n_err = 0;

  // Reference state.
  logic [63:0] m_pc, m_id_pc;
  logic [31:0] m_instr;
  logic        m_valid;
  int          m_sc, m_fc, m_consec;
  logic        m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = '0; m_id_pc = '0; m_instr = '0; m_valid = 1'b0;
    m_sc = 0; m_fc = 0; m_consec = 0; m_err = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".IF_pc"},       bus.IF_pc,       m_pc);
    chk({tag, ".ID_pc"},       bus.ID_pc,       m_id_pc);
    chk({tag, ".ID_instr"},    64'(bus.ID_instr), 64'(m_instr));
    chk({tag, ".ID_valid"},    64'(bus.ID_valid), 64'(m_valid));
    chk({tag, ".stall_count"}, 64'(bus.stall_count), 64'(m_sc));
    chk({tag, ".flush_count"}, 64'(bus.flush_count), 64'(m_fc));
    chk({tag, ".stall_err"},   64'(bus.stall_err), 64'(m_err));
  endtask

  // Called just after a negedge; applies one cycle and returns just after the next negedge.
  task automatic step(input logic s, input logic f, input logic [63:0] tgt);
    bus.stall = s; bus.flush = f; bus.branch_target = tgt;
    #1 chk("EX_bubble", 64'(bus.EX_bubble), 64'(s | f));
    @(posedge clk);
    if (f) begin
      m_pc = tgt; m_id_pc = '0; m_instr = '0; m_valid = 1'b0;
      m_fc = (m_fc < CNT_MAX) ? m_fc + 1 : m_fc;
      m_consec = 0;
    end else if (s) begin
      m_sc = (m_sc < CNT_MAX) ? m_sc + 1 : m_sc;
      m_consec++;
      if (m_consec > MAX_STALL) m_err = 1'b1;
    end else begin
      m_id_pc = m_pc; m_instr = 32'hA000_0000 + m_pc[31:0]; m_valid = 1'b1;
      m_pc = m_pc + 64'd4;
      m_consec = 0;
    end
    #1 check_all("step");
    @(negedge clk);
  endtask

  // Asynchronous reset pulse in the middle of a stall cycle.
  task automatic async_reset();
    bus.stall = 1'b1; bus.flush = 1'b0;
    #2 reset = 1'b0;
    model_reset();
    #1 check_all("async_rst");
    @(posedge clk);
    #1 check_all("rst_held");
    @(negedge clk);
    reset = 1'b1;
    bus.stall = 1'b0;
  endtask

  initial begin
    int r;
    logic [63:0] tgt;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.branch_target = '0;
    reset = 1'b1;
    model_reset();
    #1 reset = 1'b0;
    #1 check_all("reset");
    @(negedge clk);
    reset = 1'b1;

    // Plain run.
    step(0, 0, '0);
    step(0, 0, '0);
    chk("tp_run_IF_pc", bus.IF_pc, 64'd8);
    // Single stall at IF_pc=8.
    step(1, 0, '0);
    chk("tp_stall_hold", bus.IF_pc, 64'd8);
    chk("tp_stall_cnt", 64'(bus.stall_count), 64'd1);
    step(0, 0, '0);
    step(0, 0, '0);
    // Flush at IF_pc=16.
    step(0, 1, 64'h100);
    chk("tp_flush_pc", bus.IF_pc, 64'h100);
    chk("tp_flush_valid", 64'(bus.ID_valid), 64'd0);
    step(0, 0, '0);
    chk("tp_flush_idpc", bus.ID_pc, 64'h100);
    // Simultaneous stall and flush.
    step(1, 1, 64'h40);
    chk("tp_both_pc", bus.IF_pc, 64'h40);
    chk("tp_both_scnt", 64'(bus.stall_count), 64'd1);
    chk("tp_both_fcnt", 64'(bus.flush_count), 64'd2);
    // Watchdog.
    step(1, 0, '0);
    step(1, 0, '0);
    chk("tp_wd_before", 64'(bus.stall_err), 64'd0);
    step(1, 0, '0);
    chk("tp_wd_trip", 64'(bus.stall_err), 64'd1);
    step(0, 0, '0);
    chk("tp_wd_sticky", 64'(bus.stall_err), 64'd1);
    chk("tp_wd_scnt", 64'(bus.stall_count), 64'd4);
    // Async reset mid-stall.
    async_reset();
    // Counter saturation.
    for (int i = 0; i < 20; i++) step(1, 0, '0);
    chk("tp_sat", 64'(bus.stall_count), 64'd15);
    for (int i = 0; i < 17; i++) step(0, 1, 64'h200);
    chk("tp_fsat", 64'(bus.flush_count), 64'd15);
    // PC wrap.
    step(0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 0, '0);
    chk("tp_wrap", bus.IF_pc, 64'd0);
    async_reset();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      tgt = {$urandom, $urandom} & ~64'h3;
      if (r < 2)       async_reset();
      else if (r < 10) step(1'($urandom_range(0, 1)), 1, tgt);
      else if (r < 45) step(1, 0, tgt);
      else             step(0, 0, tgt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end
endmodule
